// File: rtl/aes_mm_sequencer_if.sv
// Avalon-MM bus between the AES sequencer (master) and the AES register-file slave.
`default_nettype none

interface aes_mm_sequencer_if;
  logic        AVM_CS;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BYTE_EN;
  logic [3:0]  AVM_ADDR;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA;

  modport master (
    output AVM_CS, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA,
    input  AVM_READDATA
  );

  modport slave (
    input  AVM_CS, AVM_READ, AVM_WRITE, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA,
    output AVM_READDATA
  );
endinterface

`default_nettype wire

// File: rtl/aes_mm_sequencer.sv
// Hardware sequencer that loads key/ciphertext into the AES slave, starts it,
// polls for completion and reads back the plaintext, one bus transaction per cycle.
`default_nettype none

module aes_mm_sequencer #(
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [127:0]         KEY,
  input  logic [127:0]         MSG_ENC,
  output logic [127:0]         MSG_DEC,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  aes_mm_sequencer_if.master   avm
);

  localparam logic [15:0] LIMIT = POLL_LIMIT[15:0];

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_GO, S_POLL, S_FETCH, S_STOP, S_FIN
  } state_t;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic [15:0]   poll_cnt_q;
  logic [127:0]  key_q;
  logic [127:0]  msg_q;
  logic          tmo_flag_q;
  logic          rd_q;
  logic          wr_q;
  logic [3:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    word_sel_d;
  logic [31:0]   word_d;

  // Word written in the next cycle: word 0 when leaving CLR, idx+1 while in LOAD.
  always_comb begin
    word_sel_d = (state_q == S_LOAD) ? idx_q + 3'd1 : 3'd0;
    word_d     = key_q[127:96];
    case (word_sel_d)
      3'd0: word_d = key_q[127:96];
      3'd1: word_d = key_q[95:64];
      3'd2: word_d = key_q[63:32];
      3'd3: word_d = key_q[31:0];
      3'd4: word_d = msg_q[127:96];
      3'd5: word_d = msg_q[95:64];
      3'd6: word_d = msg_q[63:32];
      3'd7: word_d = msg_q[31:0];
      default: word_d = key_q[127:96];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      poll_cnt_q <= 16'd0;
      key_q      <= 128'd0;
      msg_q      <= 128'd0;
      tmo_flag_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 4'd0;
      wdata_q    <= 32'd0;
      MSG_DEC    <= 128'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      // Bus outputs are registered: each branch schedules next cycle's transaction.
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 4'd0;
      wdata_q <= 32'd0;
      DONE    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            key_q      <= KEY;
            msg_q      <= MSG_ENC;
            TIMEOUT    <= 1'b0;
            tmo_flag_q <= 1'b0;
            BUSY       <= 1'b1;
            wr_q       <= 1'b1;
            addr_q     <= 4'd15;
            state_q    <= S_CLR;
          end
        end
        S_CLR: begin
          wr_q    <= 1'b1;
          addr_q  <= 4'd0;
          wdata_q <= word_d;
          idx_q   <= 3'd0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          wr_q <= 1'b1;
          if (idx_q == 3'd7) begin
            addr_q  <= 4'd14;
            wdata_q <= 32'd1;
            state_q <= S_GO;
          end else begin
            idx_q   <= idx_q + 3'd1;
            addr_q  <= {1'b0, word_sel_d};
            wdata_q <= word_d;
          end
        end
        S_GO: begin
          rd_q       <= 1'b1;
          addr_q     <= 4'd15;
          poll_cnt_q <= 16'd0;
          state_q    <= S_POLL;
        end
        S_POLL: begin
          if (avm.AVM_READDATA[0]) begin
            rd_q    <= 1'b1;
            addr_q  <= 4'd8;
            idx_q   <= 3'd0;
            state_q <= S_FETCH;
          end else if (poll_cnt_q + 16'd1 == LIMIT) begin
            tmo_flag_q <= 1'b1;
            wr_q       <= 1'b1;
            addr_q     <= 4'd14;
            state_q    <= S_STOP;
          end else begin
            poll_cnt_q <= poll_cnt_q + 16'd1;
            rd_q       <= 1'b1;
            addr_q     <= 4'd15;
          end
        end
        S_FETCH: begin
          case (idx_q[1:0])
            2'd0: MSG_DEC[127:96] <= avm.AVM_READDATA;
            2'd1: MSG_DEC[95:64]  <= avm.AVM_READDATA;
            2'd2: MSG_DEC[63:32]  <= avm.AVM_READDATA;
            default: MSG_DEC[31:0] <= avm.AVM_READDATA;
          endcase
          if (idx_q[1:0] == 2'd3) begin
            wr_q    <= 1'b1;
            addr_q  <= 4'd14;
            state_q <= S_STOP;
          end else begin
            idx_q  <= idx_q + 3'd1;
            rd_q   <= 1'b1;
            addr_q <= {2'b10, idx_q[1:0] + 2'd1};
          end
        end
        S_STOP: begin
          DONE    <= 1'b1;
          TIMEOUT <= tmo_flag_q;
          state_q <= S_FIN;
        end
        S_FIN: begin
          BUSY    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign avm.AVM_READ      = rd_q;
  assign avm.AVM_WRITE     = wr_q;
  assign avm.AVM_CS        = rd_q | wr_q;
  assign avm.AVM_BYTE_EN   = {4{rd_q | wr_q}};
  assign avm.AVM_ADDR      = addr_q;
  assign avm.AVM_WRITEDATA = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_mm_sequencer.sv
// Directed bench for aes_mm_sequencer with a behavioral AES register-file slave.
`default_nettype none

module tb_aes_mm_sequencer;
  localparam int LIMIT = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [127:0] KEY = 128'd0;
  logic [127:0] MSG_ENC = 128'd0;
  wire  [127:0] MSG_DEC;
  wire          BUSY, DONE, TIMEOUT;

  aes_mm_sequencer_if avm();

  aes_mm_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KEY(KEY), .MSG_ENC(MSG_ENC),
    .MSG_DEC(MSG_DEC), .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .avm(avm)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Behavioral slave: done bit rises on the done_at-th poll after start (0 = never).
  logic [31:0] sregs [16];
  logic [31:0] pt [4];
  int pc;
  int done_at = 1;

  always_comb begin
    avm.AVM_READDATA = 32'd0;
    if (avm.AVM_READ) begin
      if (avm.AVM_ADDR == 4'd15)
        avm.AVM_READDATA = {31'd0, (done_at != 0 && pc + 1 >= done_at)};
      else if (avm.AVM_ADDR[3:2] == 2'b10)
        avm.AVM_READDATA = pt[avm.AVM_ADDR[1:0]];
    end
  end

  always @(posedge CLK) begin
    if (RESET) begin
      pc <= 0;
      for (int i = 0; i < 16; i++) sregs[i] <= 32'd0;
    end else if (avm.AVM_WRITE) begin
      sregs[avm.AVM_ADDR] <= avm.AVM_WRITEDATA;
      if (avm.AVM_ADDR == 4'd14 && avm.AVM_WRITEDATA[0]) pc <= 0;
    end else if (avm.AVM_READ && avm.AVM_ADDR == 4'd15) begin
      pc <= pc + 1;
    end
  end

  typedef struct {
    int          cyc;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   proto_bad = 0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if ((avm.AVM_READ && avm.AVM_WRITE) ||
        (avm.AVM_CS !== (avm.AVM_READ | avm.AVM_WRITE)) ||
        (avm.AVM_BYTE_EN !== (avm.AVM_CS ? 4'hf : 4'h0)) ||
        (!avm.AVM_WRITE && avm.AVM_WRITEDATA !== 32'd0))
      proto_bad <= proto_bad + 1;
    if (avm.AVM_CS)
      log_q.push_back('{cyc, avm.AVM_WRITE, avm.AVM_ADDR, avm.AVM_WRITEDATA});
    if (DONE) done_q.push_back(cyc);
  end

  function automatic void build_exp(input int k, input logic [127:0] key,
                                    input logic [127:0] msg, input int npoll, input bit tmo);
    int c = k + 1;
    exp_q.delete();
    exp_q.push_back('{c, 1'b1, 4'd15, 32'd0}); c++;
    for (int i = 0; i < 4; i++) begin exp_q.push_back('{c, 1'b1, 4'(i), key[(3-i)*32 +: 32]}); c++; end
    for (int i = 0; i < 4; i++) begin exp_q.push_back('{c, 1'b1, 4'(i+4), msg[(3-i)*32 +: 32]}); c++; end
    exp_q.push_back('{c, 1'b1, 4'd14, 32'd1}); c++;
    for (int p = 0; p < npoll; p++) begin exp_q.push_back('{c, 1'b0, 4'd15, 32'd0}); c++; end
    if (!tmo)
      for (int i = 0; i < 4; i++) begin exp_q.push_back('{c, 1'b0, 4'(8+i), 32'd0}); c++; end
    exp_q.push_back('{c, 1'b1, 4'd14, 32'd0});
  endfunction

  task automatic launch(output int k);
    @(negedge CLK);
    k = cyc;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    total++;
    if ({BUSY, DONE, TIMEOUT, avm.AVM_CS, avm.AVM_READ, avm.AVM_WRITE} !== 6'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {BUSY, DONE, TIMEOUT, avm.AVM_CS, avm.AVM_READ, avm.AVM_WRITE});
    end
    total++;
    if (MSG_DEC !== 128'd0 || avm.AVM_ADDR !== 4'd0 || avm.AVM_WRITEDATA !== 32'd0 ||
        avm.AVM_BYTE_EN !== 4'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", MSG_DEC, avm.AVM_ADDR, avm.AVM_WRITEDATA);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_fips;
    int k;
    KEY = 128'h000102030405060708090a0b0c0d0e0f;
    MSG_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt[0] = 32'h00112233; pt[1] = 32'h44556677; pt[2] = 32'h8899aabb; pt[3] = 32'hccddeeff;
    done_at = 1;
    log_q.delete(); done_q.delete();
    launch(k);
    total++;
    if (BUSY !== 1'b1) begin bad++; $display("FAIL fips_busy got=%b want=1", BUSY); end
    repeat (25) @(negedge CLK);
    total++;
    if (MSG_DEC !== 128'h00112233445566778899aabbccddeeff) begin
      bad++; $display("FAIL fips_msg got=%h want=00112233445566778899aabbccddeeff", MSG_DEC);
    end
    total++;
    if (TIMEOUT !== 1'b0) begin bad++; $display("FAIL fips_timeout got=%b want=0", TIMEOUT); end
    total++;
    if (done_q.size() != 1 || done_q[0] != k + 17) begin
      bad++; $display("FAIL fips_done count=%0d first=%0d want count=1 at %0d",
                      done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 17);
    end
    total++;
    if (sregs[14] !== 32'd0 || sregs[0] !== 32'h00010203 || sregs[7] !== 32'h70b4c55a) begin
      bad++; $display("FAIL fips_slave got start=%h r0=%h r7=%h want 0/00010203/70b4c55a",
                      sregs[14], sregs[0], sregs[7]);
    end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL fips_idle got=%b want=0", BUSY); end
  endtask

  task automatic test_bus_order;
    int k;
    KEY = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    MSG_ENC = 128'h11111111_22222222_33333333_44444444;
    pt[0] = 32'ha5a5a5a5; pt[1] = 32'h5a5a5a5a; pt[2] = 32'h0f0f0f0f; pt[3] = 32'hf0f0f0f0;
    done_at = 3;
    log_q.delete(); done_q.delete();
    launch(k);
    build_exp(k, KEY, MSG_ENC, 3, 1'b0);
    repeat (28) @(negedge CLK);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL order_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i].cyc !== exp_q[i].cyc || log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL order_txn%0d got=c%0d w%0d a%0d d%h want=c%0d w%0d a%0d d%h", i,
                        log_q[i].cyc, log_q[i].wr, log_q[i].addr, log_q[i].data,
                        exp_q[i].cyc, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != k + 19) begin
      bad++; $display("FAIL order_done count=%0d first=%0d want at %0d",
                      done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 19);
    end
    total++;
    if (MSG_DEC !== 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0) begin
      bad++; $display("FAIL order_msg got=%h want=a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0", MSG_DEC);
    end
  endtask

  task automatic test_timeout;
    int k;
    KEY = 128'h0123456789abcdef0123456789abcdef;
    MSG_ENC = 128'hfedcba9876543210fedcba9876543210;
    pt[0] = 32'h99999999; pt[1] = 32'h99999999; pt[2] = 32'h99999999; pt[3] = 32'h99999999;
    done_at = 0;
    log_q.delete(); done_q.delete();
    launch(k);
    build_exp(k, KEY, MSG_ENC, LIMIT, 1'b1);
    repeat (25) @(negedge CLK);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL tmo_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i].cyc !== exp_q[i].cyc || log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL tmo_txn%0d got=c%0d w%0d a%0d d%h want=c%0d w%0d a%0d d%h", i,
                        log_q[i].cyc, log_q[i].wr, log_q[i].addr, log_q[i].data,
                        exp_q[i].cyc, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != k + 16) begin
      bad++; $display("FAIL tmo_done count=%0d first=%0d want at %0d",
                      done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 16);
    end
    total++;
    if (TIMEOUT !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", TIMEOUT); end
    total++;
    if (MSG_DEC !== 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0) begin
      bad++; $display("FAIL tmo_msg got=%h want=a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0", MSG_DEC);
    end
  endtask

  task automatic test_ignored_start;
    int k;
    KEY = 128'h00000000_11111111_22222222_33333333;
    MSG_ENC = 128'h44444444_55555555_66666666_77777777;
    pt[0] = 32'h10203040; pt[1] = 32'h50607080; pt[2] = 32'h90a0b0c0; pt[3] = 32'hd0e0f000;
    done_at = 1;
    log_q.delete(); done_q.delete();
    launch(k);
    build_exp(k, KEY, MSG_ENC, 1, 1'b0);
    total++;
    if (TIMEOUT !== 1'b0) begin bad++; $display("FAIL ign_tmo_clear got=%b want=0", TIMEOUT); end
    repeat (4) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (11) @(negedge CLK);
    total++;
    if (DONE !== 1'b1) begin bad++; $display("FAIL ign_fin_done got=%b want=1", DONE); end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (30) @(negedge CLK);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ign_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i].cyc !== exp_q[i].cyc || log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL ign_txn%0d got=c%0d w%0d a%0d want=c%0d w%0d a%0d", i,
                        log_q[i].cyc, log_q[i].wr, log_q[i].addr, exp_q[i].cyc, exp_q[i].wr, exp_q[i].addr);
      end
    end
    total++;
    if (done_q.size() != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_q.size()); end
  endtask

  task automatic test_back_to_back;
    int k1, k2;
    done_at = 1;
    log_q.delete(); done_q.delete();
    launch(k1);
    repeat (16) @(negedge CLK);
    launch(k2);
    repeat (25) @(negedge CLK);
    total++;
    if (log_q.size() != 32) begin
      bad++; $display("FAIL b2b_len got=%0d want=32", log_q.size());
    end else begin
      total++;
      if (log_q[16].cyc != k1 + 19 || log_q[16].wr !== 1'b1 || log_q[16].addr !== 4'd15) begin
        bad++; $display("FAIL b2b_second_clr got=c%0d w%0d a%0d want=c%0d w1 a15",
                        log_q[16].cyc, log_q[16].wr, log_q[16].addr, k1 + 19);
      end
    end
    total++;
    if (done_q.size() != 2 || done_q[0] != k1 + 17 || done_q[1] != k1 + 35) begin
      bad++; $display("FAIL b2b_done count=%0d want 2 at %0d,%0d", done_q.size(), k1 + 17, k1 + 35);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    done_at = 0;
    launch(k);
    repeat (11) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    total++;
    if ({avm.AVM_CS, avm.AVM_READ, avm.AVM_WRITE, BUSY} !== 4'd0 || avm.AVM_ADDR !== 4'd0 ||
        avm.AVM_BYTE_EN !== 4'd0) begin
      bad++; $display("FAIL rstmid_bus got=%b addr=%h want=0000 addr=0",
                      {avm.AVM_CS, avm.AVM_READ, avm.AVM_WRITE, BUSY}, avm.AVM_ADDR);
    end
    total++;
    if (MSG_DEC !== 128'd0) begin bad++; $display("FAIL rstmid_msg got=%h want=0", MSG_DEC); end
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    KEY = 128'h13579bdf_2468ace0_fdb97531_0eca8642;
    MSG_ENC = 128'h0badf00d_feedface_8badf00d_c0ffee00;
    pt[0] = 32'h01010101; pt[1] = 32'h02020202; pt[2] = 32'h03030303; pt[3] = 32'h04040404;
    done_at = 2;
    log_q.delete(); done_q.delete();
    launch(k);
    build_exp(k, KEY, MSG_ENC, 2, 1'b0);
    repeat (25) @(negedge CLK);
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rstmid_len got=%0d want=%0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i].cyc !== exp_q[i].cyc || log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
        bad++; $display("FAIL rstmid_txn%0d got=c%0d w%0d a%0d d%h want=c%0d w%0d a%0d d%h", i,
                        log_q[i].cyc, log_q[i].wr, log_q[i].addr, log_q[i].data,
                        exp_q[i].cyc, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != k + 18) begin
      bad++; $display("FAIL rstmid_done count=%0d want 1 at %0d", done_q.size(), k + 18);
    end
    total++;
    if (MSG_DEC !== 128'h01010101_02020202_03030303_04040404) begin
      bad++; $display("FAIL rstmid_msg2 got=%h want=01010101020202020303030304040404", MSG_DEC);
    end
  endtask

  task automatic test_protocol;
    total++;
    if (proto_bad != 0) begin bad++; $display("FAIL protocol_violations got=%0d want=0", proto_bad); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_bus_order();
    test_timeout();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
